// File: rtl/multi_datapath_p_pkg.sv
// multi_datapath_p_pkg: opcodes, FSM states, flag indices and instruction field offsets
package multi_datapath_p_pkg;
    localparam int OP_NOP  = 0;
    localparam int OP_LDI  = 1;
    localparam int OP_ADD  = 2;
    localparam int OP_SUB  = 3;
    localparam int OP_AND  = 4;
    localparam int OP_OR   = 5;
    localparam int OP_XOR  = 6;
    localparam int OP_MOV  = 7;
    localparam int OP_SHL  = 8;
    localparam int OP_CMP  = 9;
    localparam int OP_HALT = 31;

    localparam int FZ = 3;
    localparam int FN = 2;
    localparam int FC = 1;
    localparam int FV = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    // Instruction word is {opcode, rs, rd, imm}, MSB to LSB
    function automatic int rd_lo(input int imm_w);
        return imm_w;
    endfunction

    function automatic int rs_lo(input int imm_w, input int reg_w);
        return imm_w + reg_w;
    endfunction
endpackage

// File: rtl/multi_datapath_p_alu.sv
// alu_p: combinational result, write-enable, illegal flag and next flags for one opcode
module alu_p
    import multi_datapath_p_pkg::*;
#(
    parameter int DATA_WIDTH = 36,
    parameter int OPC_WIDTH  = 5
) (
    input  logic [OPC_WIDTH-1:0]  op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    input  logic [3:0]            flags_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [3:0]            flags_o,
    output logic                  wr_o,
    output logic                  illegal_o
);
    localparam int M = DATA_WIDTH - 1;

    logic [DATA_WIDTH:0] sum;
    logic [DATA_WIDTH:0] diff;
    logic                zn;

    always_comb begin
        sum       = {1'b0, a_i} + {1'b0, b_i};
        diff      = {1'b0, a_i} - {1'b0, b_i};
        result_o  = a_i;
        flags_o   = flags_i;
        wr_o      = 1'b0;
        illegal_o = 1'b0;
        zn        = 1'b0;
        case (int'(op_i))
            OP_NOP, OP_HALT: ;
            OP_LDI: begin
                result_o = imm_i;
                wr_o     = 1'b1;
            end
            OP_ADD: begin
                result_o    = sum[M:0];
                wr_o        = 1'b1;
                zn          = 1'b1;
                flags_o[FC] = sum[DATA_WIDTH];
                flags_o[FV] = (a_i[M] == b_i[M]) && (sum[M] != a_i[M]);
            end
            OP_SUB, OP_CMP: begin
                result_o    = diff[M:0];
                wr_o        = int'(op_i) == OP_SUB;
                zn          = 1'b1;
                flags_o[FC] = diff[DATA_WIDTH];
                flags_o[FV] = (a_i[M] != b_i[M]) && (diff[M] != a_i[M]);
            end
            OP_AND, OP_OR, OP_XOR: begin
                result_o    = int'(op_i) == OP_AND ? a_i & b_i :
                              int'(op_i) == OP_OR  ? a_i | b_i : a_i ^ b_i;
                wr_o        = 1'b1;
                zn          = 1'b1;
                flags_o[FC] = 1'b0;
                flags_o[FV] = 1'b0;
            end
            OP_MOV: begin
                result_o = b_i;
                wr_o     = 1'b1;
            end
            OP_SHL: begin
                result_o    = {a_i[M-1:0], 1'b0};
                wr_o        = 1'b1;
                zn          = 1'b1;
                flags_o[FC] = a_i[M];
                flags_o[FV] = 1'b0;
            end
            default: illegal_o = 1'b1;
        endcase
        if (zn) begin
            flags_o[FZ] = result_o == '0;
            flags_o[FN] = result_o[M];
        end
    end
endmodule

// File: rtl/multi_datapath_p.sv
// multi_datapath_p: multi-cycle datapath with fetch handshake, regfile, ALU and registered flags
module multi_datapath_p
    import multi_datapath_p_pkg::*;
#(
    parameter int DATA_WIDTH = 36,
    parameter int REG_ADDR_W = 5,
    parameter int IMM_WIDTH  = 8,
    parameter int OPC_WIDTH  = 5,
    localparam int INSTR_WIDTH = OPC_WIDTH + 2 * REG_ADDR_W + IMM_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    output logic                   fetch_req,
    input  logic                   fetch_ack,
    input  logic [INSTR_WIDTH-1:0] fetch_data,
    output logic                   busy,
    output logic                   halted,
    output logic                   retire,
    output logic                   illegal,
    output logic [3:0]             flags,
    input  logic [REG_ADDR_W-1:0]  dbg_addr,
    output logic [DATA_WIDTH-1:0]  dbg_data
);
    localparam int NREG  = 2 ** REG_ADDR_W;
    localparam int RD_LO = rd_lo(IMM_WIDTH);
    localparam int RS_LO = rs_lo(IMM_WIDTH, REG_ADDR_W);

    state_t                  state_q;
    logic [INSTR_WIDTH-1:0]  ir_q;
    logic [DATA_WIDTH-1:0]   rf_q [NREG];
    logic [DATA_WIDTH-1:0]   opa_q, opb_q, res_q;
    logic [3:0]              flags_q;
    logic                    wr_q, fetch_req_q, busy_q, halted_q, retire_q, illegal_q;

    logic [OPC_WIDTH-1:0]    opc;
    logic [REG_ADDR_W-1:0]   rs, rd;
    logic [DATA_WIDTH-1:0]   res_d;
    logic [3:0]              flags_d;
    logic                    wr_d, illegal_d;

    assign opc = ir_q[INSTR_WIDTH-1 -: OPC_WIDTH];
    assign rs  = ir_q[RS_LO +: REG_ADDR_W];
    assign rd  = ir_q[RD_LO +: REG_ADDR_W];

    alu_p #(.DATA_WIDTH(DATA_WIDTH), .OPC_WIDTH(OPC_WIDTH)) u_alu (
        .op_i      (opc),
        .a_i       (opa_q),
        .b_i       (opb_q),
        .imm_i     (DATA_WIDTH'(ir_q[IMM_WIDTH-1:0])),
        .flags_i   (flags_q),
        .result_o  (res_d),
        .flags_o   (flags_d),
        .wr_o      (wr_d),
        .illegal_o (illegal_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ir_q        <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            res_q       <= '0;
            flags_q     <= '0;
            wr_q        <= 1'b0;
            fetch_req_q <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            retire_q    <= 1'b0;
            illegal_q   <= 1'b0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            retire_q  <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                S_IDLE: if (run) begin
                    state_q     <= S_FETCH;
                    fetch_req_q <= 1'b1;
                    busy_q      <= 1'b1;
                end
                S_FETCH: if (fetch_ack) begin
                    ir_q        <= fetch_data;
                    fetch_req_q <= 1'b0;
                    state_q     <= S_DECODE;
                end
                S_DECODE: begin
                    opa_q   <= rf_q[rd];
                    opb_q   <= rf_q[rs];
                    state_q <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    res_q     <= res_d;
                    flags_q   <= flags_d;
                    wr_q      <= wr_d;
                    retire_q  <= 1'b1;
                    illegal_q <= illegal_d;
                    state_q   <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    if (wr_q) rf_q[rd] <= res_q;
                    if (int'(opc) == OP_HALT) begin
                        state_q  <= S_HALT;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        state_q     <= S_FETCH;
                        fetch_req_q <= 1'b1;
                    end
                end
                S_HALT: ;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign fetch_req = fetch_req_q;
    assign busy      = busy_q;
    assign halted    = halted_q;
    assign retire    = retire_q;
    assign illegal   = illegal_q;
    assign flags     = flags_q;
    assign dbg_data  = rf_q[dbg_addr];
endmodule

// File: tb/tb_multi_datapath_p.sv
// tb_multi_datapath_p: scoreboard bench for the multi-cycle datapath, plus a 16-bit width sweep
module tb_multi_datapath_p;
    localparam int DW = 36, RA = 5, IW = 8, OW = 5;
    localparam int INW = OW + 2 * RA + IW;
    localparam int BDW = 16, BRA = 3;
    localparam int BINW = OW + 2 * BRA + IW;

    typedef struct {
        int            rd;
        logic [DW-1:0] val;
        logic [3:0]    fl;
        logic          ill;
    } exp_t;

    logic clk = 1'b0, reset = 1'b0, run = 1'b0;
    logic fetch_req, fetch_ack = 1'b0, busy, halted, retire, illegal;
    logic [INW-1:0] fetch_data = '0;
    logic [3:0] flags;
    logic [RA-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_data;

    logic b_fetch_req, b_fetch_ack = 1'b0, b_busy, b_halted, b_retire, b_illegal;
    logic [BINW-1:0] b_fetch_data = '0;
    logic [3:0] b_flags;
    logic [BRA-1:0] b_dbg_addr = '0;
    logic [BDW-1:0] b_dbg_data;

    exp_t sb[$];
    logic [DW-1:0] mreg [32];
    logic [3:0] mfl;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    multi_datapath_p dut (
        .clk(clk), .reset(reset), .run(run), .fetch_req(fetch_req), .fetch_ack(fetch_ack),
        .fetch_data(fetch_data), .busy(busy), .halted(halted), .retire(retire), .illegal(illegal),
        .flags(flags), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    multi_datapath_p #(.DATA_WIDTH(BDW), .REG_ADDR_W(BRA)) dut16 (
        .clk(clk), .reset(reset), .run(run), .fetch_req(b_fetch_req), .fetch_ack(b_fetch_ack),
        .fetch_data(b_fetch_data), .busy(b_busy), .halted(b_halted), .retire(b_retire),
        .illegal(b_illegal), .flags(b_flags), .dbg_addr(b_dbg_addr), .dbg_data(b_dbg_data)
    );

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        mfl = '0;
    endtask

    // Reference behaviour: flags {Z,N,C,V}, carry via unsigned wrap, borrow via unsigned compare
    task automatic model(input int opc, input int rs, input int rd, input int imm, output exp_t e);
        logic [DW-1:0] a, b, r;
        logic [3:0] f;
        logic wr, zn;
        a = mreg[rd]; b = mreg[rs]; r = a; f = mfl; wr = 0; zn = 0; e.ill = 0;
        case (opc)
            0, 31: ;
            1: begin r = DW'(imm); wr = 1; end
            2: begin r = a + b; wr = 1; zn = 1; f[1] = r < a;
                     f[0] = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]); end
            3, 9: begin r = a - b; wr = (opc == 3); zn = 1; f[1] = a < b;
                     f[0] = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]); end
            4: begin r = a & b; wr = 1; zn = 1; f[1:0] = 2'b00; end
            5: begin r = a | b; wr = 1; zn = 1; f[1:0] = 2'b00; end
            6: begin r = a ^ b; wr = 1; zn = 1; f[1:0] = 2'b00; end
            7: begin r = b; wr = 1; end
            8: begin r = a << 1; wr = 1; zn = 1; f[1] = a[DW-1]; f[0] = 1'b0; end
            default: e.ill = 1;
        endcase
        if (zn) begin f[3] = (r == '0); f[2] = r[DW-1]; end
        if (wr) mreg[rd] = r;
        mfl = f;
        e.rd = rd; e.val = mreg[rd]; e.fl = f;
    endtask

    // Serves one fetch with the given wait cycles; lat counts cycles from first fetch_req cycle to retire
    task automatic issue(input int opc, input int rs, input int rd, input int imm, input int waits, output int lat);
        exp_t e;
        int n;
        model(opc, rs, rd, imm, e);
        sb.push_back(e);
        n = 0;
        lat = 0;
        while (!fetch_req && n < 50) begin @(negedge clk); n++; end
        if (!fetch_req) begin
            total++; bad++;
            $display("FAIL fetch_timeout: fetch_req=%0b want 1", fetch_req);
            return;
        end
        lat = 1;
        repeat (waits) begin @(negedge clk); lat++; end
        fetch_ack = 1'b1;
        fetch_data = {OW'(opc), RA'(rs), RA'(rd), IW'(imm)};
        @(negedge clk); lat++;
        fetch_ack = 1'b0;
        fetch_data = '0;
        n = 0;
        while (!retire && n < 20) begin @(negedge clk); lat++; n++; end
        total++;
        if (!retire || sb.size() == 0) begin
            bad++;
            $display("FAIL retire_timeout: retire=%0b want 1 (queued=%0d)", retire, sb.size());
            return;
        end
        e = sb.pop_front();
        total++;
        if (illegal !== e.ill) begin bad++; $display("FAIL illegal op%0d: got %0b want %0b", opc, illegal, e.ill); end
        total++;
        if (flags !== e.fl) begin bad++; $display("FAIL flags op%0d: got %b want %b", opc, flags, e.fl); end
        @(negedge clk);
        dbg_addr = RA'(e.rd);
        #1;
        total++;
        if (dbg_data !== e.val) begin bad++; $display("FAIL reg r%0d op%0d: got %h want %h", e.rd, opc, dbg_data, e.val); end
    endtask

    task automatic issue16(input int opc, input int rs, input int rd, input int imm);
        int n = 0;
        while (!b_fetch_req && n < 50) begin @(negedge clk); n++; end
        b_fetch_ack = 1'b1;
        b_fetch_data = {OW'(opc), BRA'(rs), BRA'(rd), IW'(imm)};
        @(negedge clk);
        b_fetch_ack = 1'b0;
        n = 0;
        while (!b_retire && n < 20) begin @(negedge clk); n++; end
        if (!b_retire) begin
            total++; bad++;
            $display("FAIL retire16_timeout: retire=%0b want 1", b_retire);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_clear();
    endtask

    task automatic pulse_run();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        total++;
        if (got !== want) begin bad++; $display("FAIL %s: got %h want %h", name, got, want); end
    endtask

    task automatic read_reg(input int r, output logic [DW-1:0] v);
        dbg_addr = RA'(r);
        #1;
        v = dbg_data;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if ({fetch_req, busy, halted, retire, illegal, flags} !== 9'b0) begin
            bad++; $display("FAIL reset_outputs: got %b want 0", {fetch_req, busy, halted, retire, illegal, flags});
        end
        dbg_addr = 5'd3;
        #1;
        total++;
        if (dbg_data !== '0) begin bad++; $display("FAIL reset_reg: got %h want 0", dbg_data); end
    endtask

    task automatic test_ldi();
        int lat;
        logic [DW-1:0] v;
        pulse_run();
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_run: got %b want 1", busy); end
        issue(1, 0, 3, 8'hA5, 2, lat);
        total++;
        if (lat != 6) begin bad++; $display("FAIL ldi_latency: got %0d want 6", lat); end
        read_reg(3, v);
        chk("ldi_r3", v, 36'hA5);
        chk("ldi_flags", 36'(flags), 36'h0);
    endtask

    task automatic test_add();
        int lat;
        logic [DW-1:0] v;
        issue(1, 0, 1, 8'hFF, 0, lat);
        total++;
        if (lat != 4) begin bad++; $display("FAIL min_latency: got %0d want 4", lat); end
        issue(1, 0, 2, 8'h01, 1, lat);
        issue(2, 2, 1, 0, 0, lat);
        read_reg(1, v);
        chk("add_r1", v, 36'h100);
        chk("add_flags", 36'(flags), 36'b0000);
        issue(1, 0, 1, 0, 0, lat);
        issue(3, 2, 1, 0, 0, lat);
        read_reg(1, v);
        chk("sub_allones", v, {DW{1'b1}});
        issue(2, 2, 1, 0, 3, lat);
        read_reg(1, v);
        chk("add_wrap_r1", v, 36'h0);
        chk("add_wrap_flags", 36'(flags), 36'b1010);
        issue(6, 1, 1, 0, 0, lat);
        issue(1, 0, 7, 8'h3C, 0, lat);
        issue(4, 2, 7, 0, 0, lat);
        issue(5, 7, 7, 0, 0, lat);
    endtask

    task automatic test_cmp();
        int lat;
        logic [DW-1:0] v;
        issue(1, 0, 4, 3, 0, lat);
        issue(1, 0, 5, 7, 0, lat);
        issue(9, 5, 4, 0, 1, lat);
        read_reg(4, v);
        chk("cmp_r4", v, 36'h3);
        chk("cmp_flags", 36'(flags), 36'b0110);
        issue(7, 4, 6, 0, 0, lat);
        read_reg(6, v);
        chk("mov_r6", v, 36'h3);
        chk("mov_flags", 36'(flags), 36'b0110);
        issue(8, 0, 6, 0, 0, lat);
    endtask

    task automatic test_illegal_halt();
        int lat, viol;
        logic [DW-1:0] v;
        issue(12, 5, 4, 8'h33, 1, lat);
        read_reg(4, v);
        chk("illegal_r4", v, 36'h3);
        issue(31, 0, 0, 0, 0, lat);
        total++;
        if ({halted, busy, fetch_req} !== 3'b100) begin
            bad++; $display("FAIL halt_state: got %b want 100", {halted, busy, fetch_req});
        end
        viol = 0;
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            fetch_ack = i[0];
            @(negedge clk);
            if (fetch_req !== 1'b0 || halted !== 1'b1 || retire !== 1'b0) viol++;
        end
        run = 1'b0;
        fetch_ack = 1'b0;
        total++;
        if (viol != 0) begin bad++; $display("FAIL halt_hold: got %0d bad cycles want 0", viol); end
    endtask

    task automatic test_reset_mid();
        int nz;
        do_reset();
        pulse_run();
        total++;
        if (fetch_req !== 1'b1) begin bad++; $display("FAIL mid_req: got %b want 1", fetch_req); end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({fetch_req, busy} !== 2'b00) begin bad++; $display("FAIL async_drop: got %b want 00", {fetch_req, busy}); end
        nz = 0;
        for (int i = 0; i < 32; i++) begin
            dbg_addr = RA'(i);
            #1;
            if (dbg_data !== '0) nz++;
        end
        total++;
        if (nz != 0) begin bad++; $display("FAIL reset_regs: got %0d nonzero want 0", nz); end
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if ({fetch_req, busy, halted, flags} !== 7'b0) begin
            bad++; $display("FAIL idle_wait: got %b want 0", {fetch_req, busy, halted, flags});
        end
    endtask

    task automatic test_width();
        do_reset();
        pulse_run();
        issue16(1, 0, 2, 8'hC3);
        b_dbg_addr = 3'd2;
        #1;
        chk("w16_ldi", 36'(b_dbg_data), 36'h00C3);
        issue16(1, 0, 1, 8'h80);
        for (int i = 0; i < 8; i++) issue16(8, 0, 1, 0);
        b_dbg_addr = 3'd1;
        #1;
        chk("w16_8000", 36'(b_dbg_data), 36'h8000);
        chk("w16_flags_n", 36'(b_flags), 36'b0100);
        issue16(8, 0, 1, 0);
        #1;
        chk("w16_shl0", 36'(b_dbg_data), 36'h0);
        chk("w16_flags", 36'(b_flags), 36'b1010);
    endtask

    initial begin
        model_clear();
        test_reset();
        test_ldi();
        test_add();
        test_cmp();
        test_illegal_halt();
        test_reset_mid();
        test_width();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: time=%0t want finish", $time);
        $fatal(1);
    end
endmodule

// File: doc/multi_datapath_p.md
Name: multi_datapath_p

Overview:
- Parametrised, multi-cycle successor to the fixed-width datapath: instruction register, decoder, N-entry register file, ALU with registered flags, and immediate-select write-back, all run by an internal FSM.
- Adds what the fixed block lacks:
  - fetch request/acknowledge handshake to instruction memory
  - run/halt control
  - registered flags
  - retire pulse
  - debug register read port
- Sits between the instruction memory interface and the rest of the processor top level.

Parameters:
- DATA_WIDTH, 36, width of registers, ALU and write-back path
- REG_ADDR_W, 5, register address width; register count = 2**REG_ADDR_W
- IMM_WIDTH, 8, immediate field width; zero-extended to DATA_WIDTH
- OPC_WIDTH, 5, opcode field width
- INSTR_WIDTH, OPC_WIDTH+2*REG_ADDR_W+IMM_WIDTH, derived, not overridden

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  start execution from IDLE
- fetch_req  out  1  instruction fetch request
- fetch_ack  in  1  memory acknowledge; fetch_data valid while high
- fetch_data  in  INSTR_WIDTH  instruction word, format {opcode, rs, rd, imm} MSB to LSB
- busy  out  1  high in any state except IDLE and HALT
- halted  out  1  high in HALT
- retire  out  1  one-cycle pulse per completed instruction, HALT included
- illegal  out  1  one-cycle pulse, coincident with retire, for an undefined opcode
- flags  out  4  {Z,N,C,V}, registered
- dbg_addr  in  REG_ADDR_W  debug read address
- dbg_data  out  DATA_WIDTH  combinational read of regfile[dbg_addr]

Behaviour:
- Reset (reset low, async):
  - state=IDLE; all registers, instruction register, result register and flags = 0
  - all outputs 0, except dbg_data, which reflects register contents (0)
  - Reset mid-handshake abandons the fetch; fetch_req drops asynchronously.
- IDLE: run=1 at a clock edge -> FETCH next cycle. run is ignored in all other states.
- FETCH:
  - fetch_req=1 held until the edge where fetch_ack=1; fetch_data is latched into the instruction register on that edge -> DECODE.
  - No timeout. fetch_ack outside FETCH is ignored.
- DECODE (1 cycle): fields split, source operands read from the regfile into operand registers -> EXECUTE.
- EXECUTE (1 cycle): ALU result into the result register; flags updated per opcode -> WRITEBACK.
- WRITEBACK (1 cycle): regfile[rd] written if the opcode writes; retire=1 -> FETCH.
- Instruction latency = fetch wait + 3 cycles. Minimum 4 cycles with ack in the first FETCH cycle.
- Opcodes (R = rd, S = rs, imm zero-extended; results truncated to DATA_WIDTH):
  - 0 NOP
  - 1 LDI: R=imm
  - 2 ADD: R=R+S
  - 3 SUB: R=R-S
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 MOV: R=S
  - 8 SHL: R=R<<1
  - 9 CMP: flags from R-S, no write
  - 31 HALT
  - All others: treated as NOP, with illegal pulse.
- Flags:
  - Z/N computed on the result for ADD, SUB, CMP, AND, OR, XOR, SHL.
  - ADD: C = carry out of bit DATA_WIDTH-1; V = signed overflow.
  - SUB/CMP: C = borrow (R<S unsigned); V = signed overflow.
  - Logic ops: C=0, V=0.
  - SHL: C = old MSB, V=0.
  - NOP, LDI, MOV, HALT and illegal opcodes leave flags unchanged.
- HALT: retires through WRITEBACK, then enters HALT; halted=1, fetch_req=0, busy=0. Only reset exits HALT.
- Register 0 is an ordinary register, not hardwired.
- rd==rs is legal; the operand value is the pre-write value.
- dbg_data is combinational. It shows the new value from the edge after the WRITEBACK write; no bypass.

Decomposition:
- Shared package/include:
  - opcode constants
  - state encodings (IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT)
  - flag bit indices
  - field-slice helper constants derived from the parameters
- Natural sub-module: alu_p (parametrised DATA_WIDTH; combinational result plus next-flags).
- Regfile, instruction register and FSM stay in the top.

Test Plan:
- Reset, then LDI r3,0xA5 with ack after 2 wait cycles -> retire 6 cycles after fetch_req rises; dbg_addr=3 reads 0xA5; flags=0000.
- LDI r1,0xFF; LDI r2,0x01; ADD r1,r2 -> r1=0x100, Z=0, C=0. Then with r1 preloaded all-ones (36 bits, via SUB from 0) ADD r1,r2 -> r1=0, Z=1, C=1.
- LDI r4,3; LDI r5,7; CMP r4,r5 -> r4 unchanged, flags N=1, C=1, Z=0; subsequent MOV r6,r4 leaves flags unchanged.
- Opcode 12 -> illegal and retire pulse together, no register or flag change; then HALT -> halted=1, fetch_req stays 0 for 20 cycles despite fetch_ack toggling and run=1.
- Drive reset low while fetch_req=1 and fetch_ack=0 -> fetch_req falls with no clock edge; all registers read 0 and state is IDLE until run.
- Width sweep at DATA_WIDTH=16, REG_ADDR_W=3 -> SHL of 0x8000 gives 0, C=1, Z=1; LDI zero-extends the 8-bit immediate.
